// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared state encoding, digit width and time record for the countdown core
package countdown_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t SEC_TENS_MAX = 4'd5;
    localparam digit_t DIGIT_MAX    = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        digit_t min_tens;
        digit_t min_ones;
        digit_t sec_tens;
        digit_t sec_ones;
    } mmss_t;

endpackage

// File: rtl/countdown_core_tick_sync_edge.sv
// rtl/countdown_core_tick_sync_edge.sv - synchronises tick_in into clk and emits a one-cycle tick_ev per rising edge
module tick_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_in,
    output logic tick_ev
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    // tick_ev is registered so a rise shows up SYNC_STAGES+1 cycles after tick_in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync    <= '0;
            prev    <= 1'b0;
            tick_ev <= 1'b0;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], tick_in};
            prev    <= sync[SYNC_STAGES-1];
            tick_ev <= sync[SYNC_STAGES-1] & ~prev;
        end
    end

endmodule

// File: rtl/countdown_core.sv
// rtl/countdown_core.sv - BCD MM:SS countdown with preset editing, pause/resume and completion flag
module countdown_core
    import countdown_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_MIN     = 99
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_in,
    input  logic               set_mode,
    input  logic               inc_min,
    input  logic               inc_sec,
    input  logic               start_pause,
    input  logic               clear,
    output logic [DIGIT_W-1:0] min_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic               running,
    output logic               done,
    output logic [1:0]         state
);

    localparam logic [6:0] MAX_MIN_B = 7'(MAX_MIN);

    logic   tick_ev;
    mmss_t  cur;
    mmss_t  dec_val;
    mmss_t  edit_val;
    state_t st;

    tick_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .tick_in (tick_in),
        .tick_ev (tick_ev)
    );

    // Only called with a non-zero value, so min_tens never underflows.
    function automatic mmss_t bcd_dec(input mmss_t t);
        mmss_t r;
        r = t;
        if (t.sec_ones != '0) begin
            r.sec_ones = t.sec_ones - 4'd1;
        end else begin
            r.sec_ones = DIGIT_MAX;
            if (t.sec_tens != '0) begin
                r.sec_tens = t.sec_tens - 4'd1;
            end else begin
                r.sec_tens = SEC_TENS_MAX;
                if (t.min_ones != '0) begin
                    r.min_ones = t.min_ones - 4'd1;
                end else begin
                    r.min_ones = DIGIT_MAX;
                    r.min_tens = t.min_tens - 4'd1;
                end
            end
        end
        return r;
    endfunction

    function automatic mmss_t bcd_inc_min(input mmss_t t);
        mmss_t      r;
        logic [6:0] min_bin;
        r       = t;
        min_bin = {3'b000, t.min_tens} * 7'd10 + {3'b000, t.min_ones};
        if (min_bin >= MAX_MIN_B) begin
            r.min_tens = '0;
            r.min_ones = '0;
        end else if (t.min_ones == DIGIT_MAX) begin
            r.min_ones = '0;
            r.min_tens = t.min_tens + 4'd1;
        end else begin
            r.min_ones = t.min_ones + 4'd1;
        end
        return r;
    endfunction

    // Seconds wrap 59 -> 00 without carrying into the minutes.
    function automatic mmss_t bcd_inc_sec(input mmss_t t);
        mmss_t r;
        r = t;
        if (t.sec_tens == SEC_TENS_MAX && t.sec_ones == DIGIT_MAX) begin
            r.sec_tens = '0;
            r.sec_ones = '0;
        end else if (t.sec_ones == DIGIT_MAX) begin
            r.sec_ones = '0;
            r.sec_tens = t.sec_tens + 4'd1;
        end else begin
            r.sec_ones = t.sec_ones + 4'd1;
        end
        return r;
    endfunction

    function automatic mmss_t apply_edit(input mmss_t t, input logic do_min, input logic do_sec);
        mmss_t r;
        r = t;
        if (do_min) r = bcd_inc_min(r);
        if (do_sec) r = bcd_inc_sec(r);
        return r;
    endfunction

    assign dec_val  = bcd_dec(cur);
    assign edit_val = apply_edit(cur, inc_min, inc_sec);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur     <= '0;
            st      <= IDLE;
            running <= 1'b0;
            done    <= 1'b0;
        end else if (clear) begin
            cur     <= '0;
            st      <= IDLE;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (start_pause) begin
                        if (cur != '0) begin
                            st      <= RUN;
                            running <= 1'b1;
                        end
                    end else if (set_mode && (inc_min || inc_sec)) begin
                        cur <= edit_val;
                    end
                end
                RUN: begin
                    // A tick coinciding with start_pause still lands before pausing.
                    if (tick_ev) begin
                        cur <= dec_val;
                        if (dec_val == '0) begin
                            st      <= DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end else if (start_pause) begin
                            st      <= PAUSE;
                            running <= 1'b0;
                        end
                    end else if (start_pause) begin
                        st      <= PAUSE;
                        running <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (start_pause) begin
                        st      <= RUN;
                        running <= 1'b1;
                    end
                end
                DONE: begin
                    if (start_pause) begin
                        st   <= IDLE;
                        done <= 1'b0;
                    end
                end
                default: begin
                    st      <= IDLE;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    assign min_tens = cur.min_tens;
    assign min_ones = cur.min_ones;
    assign sec_tens = cur.sec_tens;
    assign sec_ones = cur.sec_ones;
    assign state    = st;

endmodule

// File: tb/tb_countdown_core.sv
// tb/tb_countdown_core.sv - directed vector bench for countdown_core
module tb_countdown_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_in = 1'b0;
    logic       set_mode = 1'b0;
    logic       inc_min = 1'b0;
    logic       inc_sec = 1'b0;
    logic       start_pause = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, done;
    logic [1:0] state;

    int tests = 0;
    int fails = 0;

    countdown_core #(
        .SYNC_STAGES(2),
        .MAX_MIN(99)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_in     (tick_in),
        .set_mode    (set_mode),
        .inc_min     (inc_min),
        .inc_sec     (inc_sec),
        .start_pause (start_pause),
        .clear       (clear),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .running     (running),
        .done        (done),
        .state       (state)
    );

    always #5 clk = ~clk;

    typedef enum int {OP_RESET, OP_SETMODE, OP_INC_MIN, OP_INC_SEC, OP_START, OP_CLEAR, OP_TICK} op_e;

    typedef struct {
        string      name;
        op_e        op;
        int         n;
        logic [15:0] disp;
        logic [1:0]  st;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string nm, op_e o, int c, logic [15:0] d, logic [1:0] s);
        vec_t v;
        v.name = nm; v.op = o; v.n = c; v.disp = d; v.st = s;
        vecs.push_back(v);
    endfunction

    task automatic check(string nm, logic [15:0] exp_d, logic [1:0] exp_s);
        logic [15:0] d;
        logic        exp_run, exp_done;
        d        = {min_tens, min_ones, sec_tens, sec_ones};
        exp_run  = (exp_s == 2'd1);
        exp_done = (exp_s == 2'd3);
        tests++;
        if (d !== exp_d || state !== exp_s || running !== exp_run || done !== exp_done) begin
            fails++;
            $display("FAIL %s: got %h state=%0d running=%b done=%b, want %h state=%0d running=%b done=%b",
                     nm, d, state, running, done, exp_d, exp_s, exp_run, exp_done);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start_pause = 1'b1;
        @(negedge clk); start_pause = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
    endtask

    task automatic inc_min_n(input int n);
        repeat (n) begin
            @(negedge clk); inc_min = 1'b1;
            @(negedge clk); inc_min = 1'b0;
        end
    endtask

    task automatic inc_sec_n(input int n);
        repeat (n) begin
            @(negedge clk); inc_sec = 1'b1;
            @(negedge clk); inc_sec = 1'b0;
        end
    endtask

    task automatic tick_once();
        @(negedge clk); tick_in = 1'b1;
        repeat (5) @(negedge clk);
        tick_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic apply(input vec_t v);
        case (v.op)
            OP_RESET: begin
                @(negedge clk); rst = 1'b1;
                @(negedge clk); rst = 1'b0;
            end
            OP_SETMODE: begin
                @(negedge clk); set_mode = v.n[0];
            end
            OP_INC_MIN: inc_min_n(v.n);
            OP_INC_SEC: inc_sec_n(v.n);
            OP_START:   repeat (v.n) pulse_start();
            OP_CLEAR:   pulse_clear();
            OP_TICK:    repeat (v.n) tick_once();
            default: ;
        endcase
    endtask

    initial begin
        add("reset",        OP_RESET,   1,  16'h0000, 2'd0);
        add("start_zero",   OP_START,   1,  16'h0000, 2'd0);
        add("inc_no_set",   OP_INC_MIN, 1,  16'h0000, 2'd0);
        add("set_mode_on",  OP_SETMODE, 1,  16'h0000, 2'd0);
        add("inc_min2",     OP_INC_MIN, 2,  16'h0200, 2'd0);
        add("inc_sec61",    OP_INC_SEC, 61, 16'h0201, 2'd0);
        add("start",        OP_START,   1,  16'h0201, 2'd1);
        add("tick1",        OP_TICK,    1,  16'h0200, 2'd1);
        add("tick_borrow",  OP_TICK,    1,  16'h0159, 2'd1);
        add("pause",        OP_START,   1,  16'h0159, 2'd2);
        add("pause_ticks",  OP_TICK,    2,  16'h0159, 2'd2);
        add("resume",       OP_START,   1,  16'h0159, 2'd1);
        add("tick_run",     OP_TICK,    1,  16'h0158, 2'd1);
        add("run_inc_ign",  OP_INC_MIN, 1,  16'h0158, 2'd1);
        add("clear",        OP_CLEAR,   1,  16'h0000, 2'd0);
        add("set_0001",     OP_INC_SEC, 1,  16'h0001, 2'd0);
        add("start_0001",   OP_START,   1,  16'h0001, 2'd1);
        add("to_done",      OP_TICK,    1,  16'h0000, 2'd3);
        add("done_hold",    OP_TICK,    2,  16'h0000, 2'd3);
        add("done_exit",    OP_START,   1,  16'h0000, 2'd0);
        add("min99",        OP_INC_MIN, 99, 16'h9900, 2'd0);
        add("sec59",        OP_INC_SEC, 59, 16'h9959, 2'd0);
        add("min_wrap",     OP_INC_MIN, 1,  16'h0059, 2'd0);
        add("sec_wrap",     OP_INC_SEC, 1,  16'h0000, 2'd0);
        add("min10",        OP_INC_MIN, 10, 16'h1000, 2'd0);
        add("start10",      OP_START,   1,  16'h1000, 2'd1);
        add("min_tens_brw", OP_TICK,    1,  16'h0959, 2'd1);
        add("tick_x10",     OP_TICK,    10, 16'h0949, 2'd1);
        add("clear2",       OP_CLEAR,   1,  16'h0000, 2'd0);

        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            apply(vecs[i]);
            check(vecs[i].name, vecs[i].disp, vecs[i].st);
        end

        // Tick latency: display must not move until the fourth edge after the rise.
        inc_min_n(1);
        pulse_start();
        @(negedge clk); tick_in = 1'b1;
        repeat (3) @(negedge clk);
        check("lat_before", 16'h0100, 2'd1);
        @(negedge clk);
        check("lat_update", 16'h0059, 2'd1);
        repeat (3) @(negedge clk);
        tick_in = 1'b0;
        repeat (6) @(negedge clk);
        check("fall_ignored", 16'h0059, 2'd1);

        // start_pause coinciding with tick_ev at 00:10.
        pulse_clear();
        inc_sec_n(10);
        pulse_start();
        @(negedge clk); tick_in = 1'b1;
        repeat (3) @(negedge clk);
        start_pause = 1'b1;
        @(negedge clk); start_pause = 1'b0;
        check("pause_with_tick", 16'h0009, 2'd2);
        repeat (3) @(negedge clk);
        tick_in = 1'b0;
        repeat (4) @(negedge clk);
        repeat (3) tick_once();
        check("paused_frozen", 16'h0009, 2'd2);
        pulse_start();
        tick_once();
        check("resume_tick", 16'h0008, 2'd1);

        // clear coinciding with tick_ev wins.
        @(negedge clk); tick_in = 1'b1;
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        check("clear_with_tick", 16'h0000, 2'd0);
        repeat (3) @(negedge clk);
        tick_in = 1'b0;
        repeat (4) @(negedge clk);

        // Asynchronous reset mid-RUN at 01:23.
        inc_min_n(1);
        inc_sec_n(23);
        pulse_start();
        check("pre_reset", 16'h0123, 2'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset", 16'h0000, 2'd0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_reset", 16'h0000, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
